// File: rtl/avm_mem_responder.sv
// Avalon-MM slave memory model: pipelined fixed-latency reads, stall injection,
// backdoor preload, sticky range/protocol error flags and transaction counters.
module avm_mem_responder #(
    parameter int DATA_W = 256,
    parameter int ADDR_W = 32,
    parameter int DEPTH = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int READ_LATENCY = 2,
    parameter int MAX_PENDING = 4,
    parameter int STALL_MODE = 0,
    parameter int STALL_PERIOD = 4,
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    output logic              avs_waitrequest,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_readdatavalid,
    input  logic              ld_en,
    input  logic [IDX_W-1:0]  ld_index,
    input  logic [DATA_W-1:0] ld_data,
    output logic              err_range,
    output logic              err_proto,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count
);
    localparam int BYTES = DATA_W / 8;
    localparam logic [ADDR_W-1:0] BYTES_A = ADDR_W'(BYTES);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam int CNT_W = (STALL_PERIOD > 2) ? $clog2(STALL_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STALL_PERIOD - 1);
    localparam logic [3:0] PEND_MAX = 4'(MAX_PENDING);

    logic [DATA_W-1:0]       r_mem [DEPTH];
    logic [READ_LATENCY-1:0] r_pv;
    logic [DATA_W-1:0]       r_pd [READ_LATENCY];
    logic [3:0]              r_pending;
    logic [CNT_W-1:0]        r_stall_cnt;
    logic [15:0]             r_lfsr;
    logic                    r_err_range;
    logic                    r_err_proto;
    logic [31:0]             r_rd_count;
    logic [31:0]             r_wr_count;

    logic [ADDR_W-1:0] w_off;
    logic [ADDR_W-1:0] w_word;
    logic [IDX_W-1:0]  w_idx;
    logic              w_in_range;
    logic              w_stall;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_ld_ok;
    logic              w_lfsr_fb;
    logic [DATA_W-1:0] w_rd_data;

    // Handshake: a request is taken on any cycle where read or write is high and
    // waitrequest is low; waitrequest depends only on reset and registered state,
    // so the master may hold its request and rely on it being sampled exactly once.
    assign avs_waitrequest = reset | w_stall | (r_pending == PEND_MAX);

    always_comb begin
        w_stall = 1'b0;
        case (STALL_MODE)
            1:       w_stall = (r_stall_cnt == CNT_LAST);
            2:       w_stall = r_lfsr[0];
            default: w_stall = 1'b0;
        endcase
    end

    // Misaligned and below-base addresses are folded into the same out-of-range case.
    assign w_off      = avs_address - BASE_ADDR;
    assign w_word     = w_off / BYTES_A;
    assign w_idx      = w_word[IDX_W-1:0];
    assign w_in_range = (avs_address >= BASE_ADDR) && ((w_off % BYTES_A) == '0) && (w_word < DEPTH_A);

    assign w_wr_acc  = avs_write & ~avs_waitrequest;
    assign w_rd_acc  = avs_read & ~avs_write & ~avs_waitrequest;
    assign w_rd_data = w_in_range ? r_mem[w_idx] : '0;
    assign w_ld_ok   = (32'(ld_index) < DEPTH);
    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    // Bus write is issued last so it overrides a backdoor load to the same word.
    always_ff @(posedge clk) begin
        if (ld_en && w_ld_ok) r_mem[ld_index] <= ld_data;
        if (w_wr_acc && w_in_range) r_mem[w_idx] <= avs_writedata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pv        <= '0;
            for (int i = 0; i < READ_LATENCY; i++) r_pd[i] <= '0;
            r_pending   <= '0;
            r_stall_cnt <= '0;
            r_lfsr      <= 16'hACE1;
            r_err_range <= 1'b0;
            r_err_proto <= 1'b0;
            r_rd_count  <= '0;
            r_wr_count  <= '0;
        end else begin
            // Data stages only load behind a valid, so the last stage holds between responses.
            r_pv[0] <= w_rd_acc;
            if (w_rd_acc) r_pd[0] <= w_rd_data;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                if (r_pv[i-1]) r_pd[i] <= r_pd[i-1];
            end
            r_pending   <= r_pending + {3'b0, w_rd_acc} - {3'b0, r_pv[READ_LATENCY-1]};
            r_stall_cnt <= (r_stall_cnt == CNT_LAST) ? '0 : r_stall_cnt + 1'b1;
            r_lfsr      <= {r_lfsr[14:0], w_lfsr_fb};
            if ((w_rd_acc || w_wr_acc) && !w_in_range) r_err_range <= 1'b1;
            if (w_wr_acc && avs_read) r_err_proto <= 1'b1;
            if (w_rd_acc) r_rd_count <= r_rd_count + 32'd1;
            if (w_wr_acc) r_wr_count <= r_wr_count + 32'd1;
        end
    end

    assign avs_readdatavalid = r_pv[READ_LATENCY-1];
    assign avs_readdata      = r_pd[READ_LATENCY-1];
    assign err_range         = r_err_range;
    assign err_proto         = r_err_proto;
    assign rd_count          = r_rd_count;
    assign wr_count          = r_wr_count;
endmodule

// File: tb/tb_avm_mem_responder.sv
// Directed bench for avm_mem_responder: four instances with different latency,
// pending-cap and stall settings share one stimulus bus.
module tb_avm_mem_responder;
    localparam int DW = 256;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   address;
    logic          read;
    logic          write;
    logic [DW-1:0] writedata;
    logic          ld_en;
    logic [5:0]    ld_index;
    logic [DW-1:0] ld_data;

    logic          wait_o [4];
    logic [DW-1:0] rdata_o [4];
    logic          rdv_o [4];
    logic          err_range_o [4];
    logic          err_proto_o [4];
    logic [31:0]   rd_cnt_o [4];
    logic [31:0]   wr_cnt_o [4];

    int n_checks = 0;
    int n_fail = 0;
    logic [DW-1:0] exp_q [$];
    int            acc_q [$];

    localparam logic [DW-1:0] P0 = {{7{32'h5A5A_5A5A}}, 32'h0000_0123};
    localparam logic [DW-1:0] PA = {8{32'hA0A0_0001}};
    localparam logic [DW-1:0] PB = {8{32'hB0B0_0002}};
    localparam logic [DW-1:0] PE = {8{32'hE0E0_0003}};
    localparam logic [DW-1:0] PG = {8{32'h6060_0004}};

    avm_mem_responder u0 (
        .clk(clk), .reset(reset), .avs_address(address), .avs_read(read), .avs_write(write),
        .avs_writedata(writedata), .avs_waitrequest(wait_o[0]), .avs_readdata(rdata_o[0]),
        .avs_readdatavalid(rdv_o[0]), .ld_en(ld_en), .ld_index(ld_index), .ld_data(ld_data),
        .err_range(err_range_o[0]), .err_proto(err_proto_o[0]), .rd_count(rd_cnt_o[0]), .wr_count(wr_cnt_o[0]));

    avm_mem_responder #(.READ_LATENCY(4), .MAX_PENDING(2)) u1 (
        .clk(clk), .reset(reset), .avs_address(address), .avs_read(read), .avs_write(write),
        .avs_writedata(writedata), .avs_waitrequest(wait_o[1]), .avs_readdata(rdata_o[1]),
        .avs_readdatavalid(rdv_o[1]), .ld_en(ld_en), .ld_index(ld_index), .ld_data(ld_data),
        .err_range(err_range_o[1]), .err_proto(err_proto_o[1]), .rd_count(rd_cnt_o[1]), .wr_count(wr_cnt_o[1]));

    avm_mem_responder #(.STALL_MODE(1), .STALL_PERIOD(4)) u2 (
        .clk(clk), .reset(reset), .avs_address(address), .avs_read(read), .avs_write(write),
        .avs_writedata(writedata), .avs_waitrequest(wait_o[2]), .avs_readdata(rdata_o[2]),
        .avs_readdatavalid(rdv_o[2]), .ld_en(ld_en), .ld_index(ld_index), .ld_data(ld_data),
        .err_range(err_range_o[2]), .err_proto(err_proto_o[2]), .rd_count(rd_cnt_o[2]), .wr_count(wr_cnt_o[2]));

    avm_mem_responder #(.MAX_PENDING(1)) u3 (
        .clk(clk), .reset(reset), .avs_address(address), .avs_read(read), .avs_write(write),
        .avs_writedata(writedata), .avs_waitrequest(wait_o[3]), .avs_readdata(rdata_o[3]),
        .avs_readdatavalid(rdv_o[3]), .ld_en(ld_en), .ld_index(ld_index), .ld_data(ld_data),
        .err_range(err_range_o[3]), .err_proto(err_proto_o[3]), .rd_count(rd_cnt_o[3]), .wr_count(wr_cnt_o[3]));

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] addr, input logic [DW-1:0] wd);
        read = rd;
        write = wr;
        address = addr;
        writedata = wd;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, '0);
        repeat (2) tick();
        reset = 1'b0;
    endtask

    function automatic logic [DW-1:0] dpat(input int i);
        logic [31:0] w;
        w = 32'hD000_0000 | 32'(i);
        return {8{w}};
    endfunction

    int idx;
    int n_rdv;
    logic [11:0] wpat;
    logic [11:0] vpat;
    logic [7:0]  spat;

    initial begin
        read = 1'b0; write = 1'b0; address = '0; writedata = '0;
        ld_en = 1'b0; ld_index = '0; ld_data = '0;
        reset = 1'b1;
        tick(); tick();
        check("rst_wait", DW'(wait_o[0]), DW'(1'b1));
        check("rst_rdv", DW'(rdv_o[0]), DW'(1'b0));
        check("rst_rdata", rdata_o[0], '0);
        check("rst_err_range", DW'(err_range_o[0]), DW'(1'b0));
        check("rst_err_proto", DW'(err_proto_o[0]), DW'(1'b0));
        check("rst_rd_count", DW'(rd_cnt_o[0]), DW'(0));
        check("rst_wr_count", DW'(wr_cnt_o[0]), DW'(0));

        // backdoor load then read on the very next cycle
        reset = 1'b0;
        ld_en = 1'b1; ld_index = 6'd0; ld_data = P0;
        drive(1'b0, 1'b0, 32'h0, '0); tick();
        ld_en = 1'b0;
        drive(1'b1, 1'b0, 32'h0, '0); check("t1_accept", DW'(wait_o[0]), DW'(1'b0)); tick();
        drive(1'b0, 1'b0, 32'h0, '0); check("t1_lat1", DW'(rdv_o[0]), DW'(1'b0)); tick();
        drive(1'b0, 1'b0, 32'h0, '0);
        check("t1_rdv", DW'(rdv_o[0]), DW'(1'b1));
        check("t1_data", rdata_o[0], P0);
        check("t1_rd_count", DW'(rd_cnt_o[0]), DW'(1));
        tick();
        drive(1'b0, 1'b0, 32'h0, '0);
        check("t1_rdv_one_cycle", DW'(rdv_o[0]), DW'(1'b0));
        check("t1_hold", rdata_o[0], P0);
        tick();

        // bus write then read-after-write; u3 has a single pending slot
        drive(1'b0, 1'b1, 32'h40, PA); check("t2_wr_accept", DW'(wait_o[0]), DW'(1'b0)); tick();
        drive(1'b1, 1'b0, 32'h40, '0); tick();
        drive(1'b0, 1'b0, 32'h0, '0);
        check("t2_mp1_wait", DW'(wait_o[3]), DW'(1'b1));
        check("t2_lat1", DW'(rdv_o[0]), DW'(1'b0));
        tick();
        drive(1'b0, 1'b0, 32'h0, '0);
        check("t2_rdv", DW'(rdv_o[0]), DW'(1'b1));
        check("t2_data", rdata_o[0], PA);
        check("t2_mp1_wait_hold", DW'(wait_o[3]), DW'(1'b1));
        tick();
        drive(1'b0, 1'b0, 32'h0, '0);
        check("t2_mp1_release", DW'(wait_o[3]), DW'(1'b0));
        check("t2_wr_count", DW'(wr_cnt_o[0]), DW'(1));
        check("t2_rd_count", DW'(rd_cnt_o[0]), DW'(2));

        // latency 4, two pending: 2 accepts, 3 blocked cycles, responses in order
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ld_en = 1'b1; ld_index = 6'(i); ld_data = dpat(i);
            drive(1'b0, 1'b0, 32'h0, '0); tick();
        end
        ld_en = 1'b0;
        reset = 1'b0;
        idx = 0; wpat = '0; vpat = '0;
        for (int c = 0; c < 18; c++) begin
            drive(c < 12, 1'b0, 32'((idx % 4) * 32), '0);
            if (c < 12) begin
                wpat = {wait_o[1], wpat[11:1]};
                vpat = {rdv_o[1], vpat[11:1]};
            end
            if (read && !wait_o[1]) begin
                exp_q.push_back(dpat(idx % 4));
                acc_q.push_back(c);
                idx++;
            end
            if (rdv_o[1]) begin
                if (exp_q.size() == 0) check("t3_extra_rsp", DW'(1'b1), DW'(1'b0));
                else begin
                    check("t3_order", rdata_o[1], exp_q.pop_front());
                    check("t3_latency", DW'(c - acc_q.pop_front()), DW'(4));
                end
            end
            tick();
        end
        check("t3_wait_pattern", DW'(wpat), DW'(12'h39C));
        check("t3_rdv_pattern", DW'(vpat), DW'(12'h630));
        check("t3_drained", DW'(exp_q.size()), DW'(0));
        check("t3_rd_count", DW'(rd_cnt_o[1]), DW'(6));

        // periodic stall: every 4th cycle blocked
        do_reset();
        spat = '0;
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, 1'b0, 32'h0, '0);
            spat = {wait_o[2], spat[7:1]};
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, '0);
        check("t4_stall_pattern", DW'(spat), DW'(8'h88));
        check("t4_rd_count", DW'(rd_cnt_o[2]), DW'(6));

        // range / alignment errors and read+write collision
        do_reset();
        drive(1'b1, 1'b0, 32'h0, '0); tick();
        drive(1'b1, 1'b0, 32'h800, '0); check("t5_err_before", DW'(err_range_o[0]), DW'(1'b0)); tick();
        drive(1'b1, 1'b0, 32'h21, '0);
        check("t5_rdv_inrange", DW'(rdv_o[0]), DW'(1'b1));
        check("t5_data_inrange", rdata_o[0], dpat(0));
        check("t5_err_range", DW'(err_range_o[0]), DW'(1'b1));
        tick();
        drive(1'b0, 1'b0, 32'h0, '0);
        check("t5_oor_rdv", DW'(rdv_o[0]), DW'(1'b1));
        check("t5_oor_data", rdata_o[0], '0);
        tick();
        drive(1'b0, 1'b0, 32'h0, '0);
        check("t5_mis_rdv", DW'(rdv_o[0]), DW'(1'b1));
        check("t5_mis_data", rdata_o[0], '0);
        tick();
        drive(1'b1, 1'b1, 32'h80, PB);
        check("t5_sticky", DW'(err_range_o[0]), DW'(1'b1));
        check("t5_proto_before", DW'(err_proto_o[0]), DW'(1'b0));
        tick();
        drive(1'b0, 1'b0, 32'h0, '0);
        check("t5_err_proto", DW'(err_proto_o[0]), DW'(1'b1));
        check("t5_wr_count", DW'(wr_cnt_o[0]), DW'(1));
        check("t5_rd_count", DW'(rd_cnt_o[0]), DW'(3));
        tick();
        drive(1'b0, 1'b0, 32'h0, '0); check("t5_no_rsp", DW'(rdv_o[0]), DW'(1'b0)); tick();
        drive(1'b1, 1'b0, 32'h80, '0); tick();
        drive(1'b0, 1'b0, 32'h0, '0); tick();
        drive(1'b0, 1'b0, 32'h0, '0);
        check("t5_rw_rdv", DW'(rdv_o[0]), DW'(1'b1));
        check("t5_rw_data", rdata_o[0], PB);
        tick();

        // reset with two reads in flight on the latency-4 instance
        do_reset();
        ld_en = 1'b1; ld_index = 6'd3; ld_data = PG;
        drive(1'b0, 1'b1, 32'h60, PE); tick();
        ld_en = 1'b0;
        drive(1'b1, 1'b0, 32'h0, '0); check("t6_acc1", DW'(wait_o[1]), DW'(1'b0)); tick();
        drive(1'b1, 1'b0, 32'h20, '0); check("t6_acc2", DW'(wait_o[1]), DW'(1'b0)); tick();
        n_rdv = 0;
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, '0);
        check("t6_wait_in_reset", DW'(wait_o[1]), DW'(1'b1));
        check("t6_wr_before", DW'(wr_cnt_o[1]), DW'(1));
        if (rdv_o[1]) n_rdv++;
        tick();
        drive(1'b0, 1'b0, 32'h0, '0);
        check("t6_rst_rdv", DW'(rdv_o[1]), DW'(1'b0));
        check("t6_rst_rdata", rdata_o[1], '0);
        check("t6_rst_wr_count", DW'(wr_cnt_o[1]), DW'(0));
        check("t6_rst_rd_count", DW'(rd_cnt_o[1]), DW'(0));
        if (rdv_o[1]) n_rdv++;
        tick();
        reset = 1'b0;
        drive(1'b1, 1'b0, 32'h60, '0);
        check("t6_post_wait", DW'(wait_o[1]), DW'(1'b0));
        if (rdv_o[1]) n_rdv++;
        tick();
        for (int c = 6; c < 9; c++) begin
            drive(1'b0, 1'b0, 32'h0, '0);
            if (rdv_o[1]) n_rdv++;
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, '0);
        check("t6_no_stale_rsp", DW'(n_rdv), DW'(0));
        check("t6_rdv", DW'(rdv_o[1]), DW'(1'b1));
        check("t6_data_kept", rdata_o[1], PE);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
